// File: rtl/block_fetch_2x2_if.sv
// rtl/block_fetch_2x2_if.sv - frame RAM read port and decimator pixel/ack handshake
interface block_fetch_2x2_if #(
  parameter int ADDR_W  = 15,
  parameter int OADDR_W = 13
);
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [7:0]         mem_rdata;
  logic               blk_start;
  logic [7:0]         pix_data;
  logic               pix_valid;
  logic [OADDR_W-1:0] out_addr;
  logic               blk_ack;

  modport master (
    output mem_rd_en, mem_addr, blk_start, pix_data, pix_valid, out_addr,
    input  mem_rdata, blk_ack
  );

  modport slave (
    input  mem_rd_en, mem_addr, blk_start, pix_data, pix_valid, out_addr,
    output mem_rdata, blk_ack
  );
endinterface

// File: rtl/block_fetch_2x2.sv
// rtl/block_fetch_2x2.sv - 2x2 block walker feeding the 2x decimator from frame RAM
// Optional abort input enabled by BLOCK_FETCH_ABORT_EN.
module block_fetch_2x2 #(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int ADDR_W  = 15,
  parameter int OADDR_W = 13
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
`ifdef BLOCK_FETCH_ABORT_EN
  input  logic abort_i,
`endif
  output logic busy_o,
  output logic done_o,
  block_fetch_2x2_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int BCOLS = IMG_W / 2;
  localparam int BROWS = IMG_H / 2;
  localparam int CW    = (BCOLS > 1) ? $clog2(BCOLS) : 1;
  localparam int RW    = (BROWS > 1) ? $clog2(BROWS) : 1;

  localparam logic [CW-1:0]      LAST_COL = CW'(BCOLS - 1);
  localparam logic [RW-1:0]      LAST_ROW = RW'(BROWS - 1);
  localparam logic [ADDR_W-1:0]  A_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  A_TWO    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0]  ROW_OFS  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]  ROW2_OFS = ADDR_W'(2 * IMG_W);
  localparam logic [OADDR_W-1:0] O_ONE    = OADDR_W'(1);

  logic [2:0]         state_q, state_d;
  logic [1:0]         rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  row_start_q, row_start_d;
  logic [CW-1:0]      bcol_q, bcol_d;
  logic [RW-1:0]      brow_q, brow_d;
  logic [OADDR_W-1:0] out_addr_q, out_addr_d;
  logic               pix_valid_q, pix_valid_d;
  logic               abort;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;

`ifdef BLOCK_FETCH_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    base_d      = base_q;
    row_start_d = row_start_q;
    bcol_d      = bcol_q;
    brow_d      = brow_q;
    out_addr_d  = out_addr_q;
    // RAM data lands one cycle after each read, so valid trails the READ state
    pix_valid_d = (state_q == S_READ) && !abort;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_READ;
          rd_cnt_d    = 2'd0;
          base_d      = '0;
          row_start_d = '0;
          bcol_d      = '0;
          brow_d      = '0;
          out_addr_d  = '0;
        end
      end
      S_READ: begin
        rd_cnt_d = rd_cnt_q + 2'd1;
        if (rd_cnt_q == 2'd3) state_d = S_LAST;
      end
      S_LAST: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.blk_ack) begin
          if (bcol_q == LAST_COL && brow_q == LAST_ROW) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_READ;
            rd_cnt_d   = 2'd0;
            out_addr_d = out_addr_q + O_ONE;
            if (bcol_q == LAST_COL) begin
              bcol_d      = '0;
              brow_d      = brow_q + 1'b1;
              row_start_d = row_start_q + ROW2_OFS;
              base_d      = row_start_q + ROW2_OFS;
            end else begin
              bcol_d = bcol_q + 1'b1;
              base_d = base_q + A_TWO;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= 2'd0;
      base_q      <= '0;
      row_start_q <= '0;
      bcol_q      <= '0;
      brow_q      <= '0;
      out_addr_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      base_q      <= base_d;
      row_start_q <= row_start_d;
      bcol_q      <= bcol_d;
      brow_q      <= brow_d;
      out_addr_q  <= out_addr_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign rd_en = (state_q == S_READ);

  always_comb begin
    rd_addr = base_q;
    case (rd_cnt_q)
      2'd0:    rd_addr = base_q;
      2'd1:    rd_addr = base_q + A_ONE;
      2'd2:    rd_addr = base_q + ROW_OFS;
      default: rd_addr = base_q + ROW_OFS + A_ONE;
    endcase
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_en ? rd_addr : '0;
  assign bus.blk_start = rd_en && (rd_cnt_q == 2'd0);
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_valid_q ? bus.mem_rdata : 8'd0;
  assign bus.out_addr  = out_addr_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
endmodule

// File: tb/tb_block_fetch_2x2.sv
// tb/tb_block_fetch_2x2.sv - scoreboard bench for block_fetch_2x2 (4x4 and 5x5 instances)
module tb_block_fetch_2x2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start4 = 1'b0, start5 = 1'b0;
  logic busy4, done4, busy5, done5;
`ifdef BLOCK_FETCH_ABORT_EN
  logic abort4 = 1'b0, abort5 = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt4 = 0, done_cnt5 = 0;
  int exp_rd4[$], exp_pix4[$], exp_oa4[$];
  int exp_rd5[$], exp_pix5[$], exp_oa5[$];

  always #5 clk = ~clk;

  block_fetch_2x2_if #(.ADDR_W(4), .OADDR_W(2)) if4();
  block_fetch_2x2_if #(.ADDR_W(5), .OADDR_W(2)) if5();

  block_fetch_2x2 #(.IMG_W(4), .IMG_H(4), .ADDR_W(4), .OADDR_W(2)) u4 (
    .clk(clk), .reset_n(reset_n), .start_i(start4),
`ifdef BLOCK_FETCH_ABORT_EN
    .abort_i(abort4),
`endif
    .busy_o(busy4), .done_o(done4), .bus(if4)
  );

  block_fetch_2x2 #(.IMG_W(5), .IMG_H(5), .ADDR_W(5), .OADDR_W(2)) u5 (
    .clk(clk), .reset_n(reset_n), .start_i(start5),
`ifdef BLOCK_FETCH_ABORT_EN
    .abort_i(abort5),
`endif
    .busy_o(busy5), .done_o(done5), .bus(if5)
  );

  // Frame RAMs with mem[i] = i and one cycle read latency
  always @(posedge clk) if (if4.mem_rd_en) if4.mem_rdata <= 8'(if4.mem_addr);
  always @(posedge clk) if (if5.mem_rd_en) if5.mem_rdata <= 8'(if5.mem_addr);

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp4();
    for (int by = 0; by < 2; by++)
      for (int bx = 0; bx < 2; bx++) begin
        int b;
        b = 2 * by * 4 + 2 * bx;
        foreach (exp_oa4[i]) ; // keep order: block index pushed below
        exp_oa4.push_back(by * 2 + bx);
        for (int k = 0; k < 4; k++) begin
          exp_rd4.push_back(b + (k / 2) * 4 + (k % 2));
          exp_pix4.push_back(b + (k / 2) * 4 + (k % 2));
        end
      end
  endtask

  task automatic push_exp5();
    for (int by = 0; by < 2; by++)
      for (int bx = 0; bx < 2; bx++) begin
        int b;
        b = 2 * by * 5 + 2 * bx;
        exp_oa5.push_back(by * 2 + bx);
        for (int k = 0; k < 4; k++) begin
          exp_rd5.push_back(b + (k / 2) * 5 + (k % 2));
          exp_pix5.push_back(b + (k / 2) * 5 + (k % 2));
        end
      end
  endtask

  task automatic flush4();
    exp_rd4.delete();
    exp_pix4.delete();
    exp_oa4.delete();
  endtask

  always @(negedge clk) if (reset_n) begin
    if (if4.mem_rd_en) begin
      if (exp_rd4.size() == 0) check("rd4_unexpected", 1, 0);
      else check("rd4_addr", int'(if4.mem_addr), exp_rd4.pop_front());
    end
    if (if4.pix_valid) begin
      if (exp_pix4.size() == 0) check("pix4_unexpected", 1, 0);
      else check("pix4_data", int'(if4.pix_data), exp_pix4.pop_front());
    end
    if (if4.blk_start) begin
      if (exp_oa4.size() == 0) check("blk4_unexpected", 1, 0);
      else check("oa4_at_start", int'(if4.out_addr), exp_oa4.pop_front());
    end
    if (done4) done_cnt4++;
  end

  always @(negedge clk) if (reset_n) begin
    if (if5.mem_rd_en) begin
      if (exp_rd5.size() == 0) check("rd5_unexpected", 1, 0);
      else check("rd5_addr", int'(if5.mem_addr), exp_rd5.pop_front());
      check("rd5_edge_skip", int'((if5.mem_addr % 5 == 4) || (if5.mem_addr / 5 == 4)), 0);
    end
    if (if5.pix_valid) begin
      if (exp_pix5.size() == 0) check("pix5_unexpected", 1, 0);
      else check("pix5_data", int'(if5.pix_data), exp_pix5.pop_front());
    end
    if (if5.blk_start) begin
      if (exp_oa5.size() == 0) check("blk5_unexpected", 1, 0);
      else check("oa5_at_start", int'(if5.out_addr), exp_oa5.pop_front());
    end
    if (done5) done_cnt5++;
  end

  task automatic wait_bs4();
    int n = 0;
    while (!if4.blk_start && n < 40) begin
      tick();
      n++;
    end
    check("blk_start4_seen", int'(if4.blk_start), 1);
  endtask

  // mode 0: full frame, 1: reset in READ of cut_block, 2: abort in WAIT_ACK of cut_block
  task automatic frame4(input int ack_delay, input int cut_block, input int mode);
    int d0;
    d0 = done_cnt4;
    push_exp4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wait_bs4();
      if (mode == 1 && b == cut_block) begin
        tick();
        reset_n = 1'b0;
        #1;
        check("rst_busy", int'(busy4), 0);
        check("rst_rd_en", int'(if4.mem_rd_en), 0);
        check("rst_addr", int'(if4.mem_addr), 0);
        check("rst_pix_valid", int'(if4.pix_valid), 0);
        check("rst_out_addr", int'(if4.out_addr), 0);
        flush4();
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_no_done", done_cnt4 - d0, 0);
        return;
      end
      repeat (2) tick();
      if (b == 0) if4.blk_ack = 1'b1;
      tick();
      if4.blk_ack = 1'b0;
      repeat (2) tick();
      check("wait_busy", int'(busy4), 1);
      check("wait_rd_en", int'(if4.mem_rd_en), 0);
      check("wait_pix_valid", int'(if4.pix_valid), 0);
      check("wait_out_addr", int'(if4.out_addr), b);
`ifdef BLOCK_FETCH_ABORT_EN
      if (mode == 2 && b == cut_block) begin
        abort4 = 1'b1;
        tick();
        abort4 = 1'b0;
        check("abort_busy", int'(busy4), 0);
        check("abort_done", int'(done4), 0);
        flush4();
        tick();
        check("abort_no_done", done_cnt4 - d0, 0);
        return;
      end
`endif
      repeat (ack_delay) tick();
      if4.blk_ack = 1'b1;
      tick();
      if4.blk_ack = 1'b0;
      if (b == 3) begin
        check("done_pulse", int'(done4), 1);
        tick();
        check("done_clear", int'(done4), 0);
        check("idle_after_done", int'(busy4), 0);
      end
    end
    check("done_count", done_cnt4 - d0, 1);
  endtask

  initial begin
    int t;
    int d0;
    if4.blk_ack = 1'b0;
    if5.blk_ack = 1'b0;
    repeat (3) tick();
    check("reset_busy", int'(busy4), 0);
    check("reset_done", int'(done4), 0);
    check("reset_rd_en", int'(if4.mem_rd_en), 0);
    check("reset_blk_start", int'(if4.blk_start), 0);
    check("reset_pix_valid", int'(if4.pix_valid), 0);
    check("reset_out_addr", int'(if4.out_addr), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Full frames with delayed ack and a stray ack during READ
    frame4(2, -1, 0);
    repeat (3) tick();

    // Ack held high: back-to-back blocks, extra starts ignored
    d0 = done_cnt4;
    push_exp4();
    if4.blk_ack = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("hold_first_blk_start", int'(if4.blk_start), 1);
    t = 0;
    while (t < 60) begin
      tick();
      t++;
      if (done4) break;
      start4 = (t % 7 == 3);
    end
    start4 = 1'b0;
    if4.blk_ack = 1'b0;
    check("hold_latency", t, 24);
    repeat (3) tick();
    check("hold_idle", int'(busy4), 0);
    check("hold_done_count", done_cnt4 - d0, 1);

    // Reset during READ of the second block, then a clean restart
    frame4(2, 1, 1);
    frame4(0, -1, 0);

`ifdef BLOCK_FETCH_ABORT_EN
    frame4(2, 0, 2);
    frame4(1, -1, 0);
`endif

    // 5x5 image: odd last column and row skipped
    push_exp5();
    if5.blk_ack = 1'b1;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    t = 0;
    while (!done5 && t < 60) begin
      tick();
      t++;
    end
    if5.blk_ack = 1'b0;
    check("img5_done", int'(done5), 1);
    repeat (3) tick();
    check("img5_done_count", done_cnt5, 1);

    check("q_rd4_drained", exp_rd4.size(), 0);
    check("q_pix4_drained", exp_pix4.size(), 0);
    check("q_oa4_drained", exp_oa4.size(), 0);
    check("q_rd5_drained", exp_rd5.size(), 0);
    check("q_pix5_drained", exp_pix5.size(), 0);
    check("q_oa5_drained", exp_oa5.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
